crc32_frame_checker: RTL and testbench
======================================

# crc32_frame_checker

Receive-side CRC-32/MPEG-2 checker (polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR) for 32-bit word streams whose last word is the CRC computed by the transmit-side word-step generator. The block accumulates the CRC over every word of a frame, including the trailing CRC word, and declares the frame good when the residue is zero. It then reports a per-frame status record and maintains saturating good/bad frame counters. It sits between the stream ingress and frame consumers.

## Interface
- INIT, 32'hFFFFFFFF: CRC register start value for every frame.
- LEN_W, 16: width of the frame-length field, in words.
- CNT_W, 16: width of the good/bad frame counters.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  checker accepts a word.
- s_data  in  32  frame word; bit mapping identical to the transmit generator's data_in.
- s_last  in  1  marks the final word of the frame, which is the CRC word.
- m_valid  out  1  status record valid.
- m_ready  in  1  status consumer ready.
- m_pass  out  1  1 = residue zero.
- m_len  out  LEN_W  words in frame, CRC word included; saturates at all-ones.
- m_residue  out  32  final CRC register value; 0 on pass.
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_good  out  CNT_W  frames passed; saturating.
- cnt_bad  out  CNT_W  frames failed; saturating.

## Operation
- Word step: next = F(crc, s_data).
  - F is the same 32-bit-parallel MPEG-2 update used by the transmit generator: crc ^ data advanced 32 bit-times through the LFSR.
  - F(x, x) = 0, so a frame whose appended word equals the running CRC yields residue 0.
- States:
  - ACCUM: s_ready = 1; m_valid = 0. Each beat (s_valid & s_ready) sets crc ← F(crc, s_data) and len ← sat(len + 1).
  - ACCUM with s_last on the beat: capture m_pass = (F(crc, s_data) == 0), m_residue = F(crc, s_data), m_len = sat(len + 1). Then reload crc ← INIT and len ← 0, and go to REPORT.
  - REPORT: s_ready = 0; m_valid = 1; the record is held stable. On m_ready, return to ACCUM.
- Counters: on the s_last beat, increment cnt_good if pass, otherwise cnt_bad. Both saturate at 2^CNT_W − 1.
- clr_cnt:
  - Zeroes both counters the next cycle.
  - If clr_cnt coincides with a counter increment, the clear wins and the counter becomes 0.
- Minimum frame: 1 word, consisting of only the CRC word. No maximum frame length; m_len saturates at 2^LEN_W − 1 while the CRC continues accumulating.
- s_data and s_last are ignored when the beat is not accepted.

## Timing
- Reset values: state ACCUM, crc = INIT, len = 0, s_ready = 1, m_valid = 0, m_pass = 0, m_len = 0, m_residue = 0, cnt_good = 0, cnt_bad = 0.
- Throughput: one word per cycle in ACCUM. There are no stall cycles inside a frame.
- Latency: m_valid rises the cycle after the s_last beat.
- REPORT exit: s_ready returns to 1 the cycle after the m_valid & m_ready handshake. The minimum gap between frames is therefore 1 cycle, with m_ready tied high.
- Back-to-back frames: the first word of the next frame is taken no earlier than the cycle after the handshake, and it starts from INIT.
- Reset mid-frame or in REPORT: return immediately to reset values. The partial frame or pending record is discarded and not counted.

## Test plan
- Single-word frame s_data = 0xFFFFFFFF, s_last = 1 → next cycle: m_valid = 1, m_pass = 1, m_residue = 0, m_len = 1, cnt_good = 1.
- Single-word frame s_data = 0xFFFFFFFE → m_pass = 0, m_residue ≠ 0, m_len = 1, cnt_bad = 1.
- 5-word frame: 4 random data words plus the CRC word from the golden word-step model, with m_ready held low for 3 cycles:
  - m_pass = 1, m_len = 5.
  - s_ready = 0 and the record is stable during the stall.
  - s_ready = 1 the cycle after the handshake.
- Same frame with bit 7 of word 2 flipped → m_pass = 0; cnt_bad increments; the following clean frame passes, which proves the CRC is reloaded to INIT.
- Reset asserted after word 3 of a 6-word frame:
  - Immediately: s_ready = 1, m_valid = 0, counters = 0.
  - A subsequent clean 2-word frame passes with m_len = 2.
- Counter bounds:
  - With CNT_W = 2, after 5 good frames cnt_good = 3.
  - clr_cnt asserted on the same cycle as a good s_last beat gives cnt_good = 0 the next cycle.
  - With LEN_W = 2, a 6-word clean frame reports m_len = 3 and m_pass = 1.

Source files
------------

// File: rtl/crc32_frame_checker.sv
// Purpose : receive-side CRC-32/MPEG-2 frame checker; residue over data+CRC word must be zero.
// Latency : status record valid the cycle after the s_last beat; one word per cycle inside a frame.
// Backpressure: s_ready drops while a record is pending; it returns the cycle after m_valid & m_ready.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready     - word stream handshake; s_data is the word, s_last marks the CRC word
//   m_valid/m_ready     - status record handshake; m_pass, m_len, m_residue form the record
//   clr_cnt             - synchronous clear of both frame counters (wins over an increment)
//   cnt_good, cnt_bad   - saturating passed/failed frame counters
module crc32_frame_checker #(
  parameter logic [31:0] INIT  = 32'hFFFF_FFFF,
  parameter int          LEN_W = 16,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_pass,
  output logic [LEN_W-1:0] m_len,
  output logic [31:0]      m_residue,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  // 32-bit parallel step: fold the word into the register, then clock the
  // LFSR 32 times. Feeding the running CRC back in as data cancels to zero.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int i = 0; i < 32; i++) begin
      if (c[31]) begin
        c = (c << 1) ^ POLY;
      end else begin
        c = c << 1;
      end
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pass_q, pass_d;
  logic [LEN_W-1:0] rec_len_q, rec_len_d;
  logic [31:0]      residue_q, residue_d;
  logic [CNT_W-1:0] cnt_good_q, cnt_good_d;
  logic [CNT_W-1:0] cnt_bad_q, cnt_bad_d;

  logic             beat;
  logic [31:0]      crc_next;
  logic [LEN_W-1:0] len_inc;
  logic             good_inc;
  logic             bad_inc;

  assign beat     = s_valid & s_ready;
  assign crc_next = crc_step(crc_q, s_data);
  // Length sticks at all-ones on very long frames; the CRC keeps running.
  assign len_inc  = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);

  // State machine and record capture
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    pass_d    = pass_q;
    rec_len_d = rec_len_q;
    residue_d = residue_q;
    good_inc  = 1'b0;
    bad_inc   = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;

    unique case (state_q)
      ST_ACCUM: begin
        s_ready = 1'b1;
        if (beat) begin
          if (s_last) begin
            // Capture the record from the post-step value, then rearm for
            // the next frame so it starts from INIT.
            pass_d    = (crc_next == 32'h0);
            residue_d = crc_next;
            rec_len_d = len_inc;
            good_inc  = (crc_next == 32'h0);
            bad_inc   = (crc_next != 32'h0);
            crc_d     = INIT;
            len_d     = '0;
            state_d   = ST_REPORT;
          end else begin
            crc_d = crc_next;
            len_d = len_inc;
          end
        end
      end
      ST_REPORT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // Saturating counters; a clear overrides a coincident increment.
  always_comb begin
    cnt_good_d = cnt_good_q;
    cnt_bad_d  = cnt_bad_q;
    if (clr_cnt) begin
      cnt_good_d = '0;
      cnt_bad_d  = '0;
    end else begin
      if (good_inc && (cnt_good_q != {CNT_W{1'b1}})) begin
        cnt_good_d = cnt_good_q + CNT_W'(1);
      end
      if (bad_inc && (cnt_bad_q != {CNT_W{1'b1}})) begin
        cnt_bad_d = cnt_bad_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      crc_q      <= INIT;
      len_q      <= '0;
      pass_q     <= 1'b0;
      rec_len_q  <= '0;
      residue_q  <= 32'h0;
      cnt_good_q <= '0;
      cnt_bad_q  <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      pass_q     <= pass_d;
      rec_len_q  <= rec_len_d;
      residue_q  <= residue_d;
      cnt_good_q <= cnt_good_d;
      cnt_bad_q  <= cnt_bad_d;
    end
  end

  assign m_pass    = pass_q;
  assign m_len     = rec_len_q;
  assign m_residue = residue_q;
  assign cnt_good  = cnt_good_q;
  assign cnt_bad   = cnt_bad_q;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Purpose : self-checking bench for crc32_frame_checker, default and narrow-counter instances.
// Latency : record expected the cycle after the s_last beat.
// Backpressure: m_ready is stalled in some scenarios to exercise the held record.
module tb_crc32_frame_checker;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_ready;
  logic        clr_cnt;

  logic        s_ready, m_valid, m_pass;
  logic [15:0] m_len;
  logic [31:0] m_residue;
  logic [15:0] cnt_good, cnt_bad;

  logic        s_ready_s, m_valid_s, m_pass_s;
  logic [1:0]  m_len_s;
  logic [31:0] m_residue_s;
  logic [1:0]  cnt_good_s, cnt_bad_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] frame[$];
  logic [31:0] saved[$];
  bit          gaps_en = 0;
  int          exp_good = 0;
  int          exp_bad  = 0;

  crc32_frame_checker dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_pass(m_pass),
    .m_len(m_len), .m_residue(m_residue), .clr_cnt(clr_cnt),
    .cnt_good(cnt_good), .cnt_bad(cnt_bad)
  );

  crc32_frame_checker #(.LEN_W(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid_s), .m_ready(m_ready), .m_pass(m_pass_s),
    .m_len(m_len_s), .m_residue(m_residue_s), .clr_cnt(clr_cnt),
    .cnt_good(cnt_good_s), .cnt_bad(cnt_bad_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain MSB-first bit-serial CRC-32/MPEG-2 over the first n words.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] r;
    logic        fb;
    r = 32'hFFFF_FFFF;
    for (int w = 0; w < n; w++) begin
      for (int b = 31; b >= 0; b--) begin
        fb = r[31] ^ frame[w][b];
        r  = {r[30:0], 1'b0};
        if (fb) r = r ^ 32'h04C1_1DB7;
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  // n_data random words followed by their CRC; optionally one bit flipped.
  task automatic build_frame(input int n_data, input int flip_w, input int flip_b);
    logic [31:0] tmp;
    frame.delete();
    for (int i = 0; i < n_data; i++) frame.push_back($urandom);
    frame.push_back(ref_crc(n_data));
    if (flip_w >= 0) begin
      tmp = frame[flip_w];
      tmp[flip_b] = ~tmp[flip_b];
      frame[flip_w] = tmp;
    end
  endtask

  // Called at a negedge; returns at the negedge after the n-th beat.
  task automatic drive_words(input int n, input bit clr_last);
    for (int i = 0; i < n; i++) begin
      if (gaps_en && ($urandom_range(0, 2) == 0)) begin
        s_valid = 1'b0; s_last = 1'b1; s_data = $urandom;
        @(posedge clk); @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = frame[i];
      s_last  = (i == frame.size() - 1);
      clr_cnt = clr_last && s_last;
      @(posedge clk); @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b1; clr_cnt = 1'b0; s_data = $urandom;
  endtask

  task automatic step;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if ({m_pass, m_len, m_residue} !== 49'h0) begin errors++; $display("FAIL reset_record: pass %b len %0d res %h want all 0", m_pass, m_len, m_residue); end
    checks++; if ({cnt_good, cnt_bad} !== 32'h0) begin errors++; $display("FAIL reset_counters: good %0d bad %0d want 0", cnt_good, cnt_bad); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_word;
    frame.delete(); frame.push_back(32'hFFFF_FFFF);
    drive_words(1, 1'b0); exp_good++;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_good_valid: got %b want 1", m_valid); end
    checks++; if ({m_pass, m_residue} !== {1'b1, 32'h0}) begin errors++; $display("FAIL single_good_pass: pass %b res %h want 1/0", m_pass, m_residue); end
    checks++; if (m_len !== 16'd1) begin errors++; $display("FAIL single_good_len: got %0d want 1", m_len); end
    checks++; if (cnt_good !== 16'(exp_good)) begin errors++; $display("FAIL single_good_cnt: got %0d want %0d", cnt_good, exp_good); end
    step();
    frame.delete(); frame.push_back(32'hFFFF_FFFE);
    drive_words(1, 1'b0); exp_bad++;
    checks++; if (m_pass !== 1'b0) begin errors++; $display("FAIL single_bad_pass: got %b want 0", m_pass); end
    checks++; if ((m_residue !== ref_crc(1)) || (m_residue == 32'h0)) begin errors++; $display("FAIL single_bad_res: got %h want %h", m_residue, ref_crc(1)); end
    checks++; if (m_len !== 16'd1) begin errors++; $display("FAIL single_bad_len: got %0d want 1", m_len); end
    checks++; if (cnt_bad !== 16'(exp_bad)) begin errors++; $display("FAIL single_bad_cnt: got %0d want %0d", cnt_bad, exp_bad); end
    step();
  endtask

  task automatic test_stall;
    logic [31:0] res0;
    logic [15:0] len0;
    logic        pass0;
    m_ready = 1'b0;
    build_frame(4, -1, 0); saved = frame;
    drive_words(5, 1'b0); exp_good++;
    pass0 = m_pass; len0 = m_len; res0 = m_residue;
    checks++; if ({m_valid, m_pass} !== 2'b11) begin errors++; $display("FAIL stall_pass: valid %b pass %b want 1/1", m_valid, m_pass); end
    checks++; if (m_len !== 16'd5) begin errors++; $display("FAIL stall_len: got %0d want 5", m_len); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ((s_ready !== 1'b0) || (m_valid !== 1'b1)) begin errors++; $display("FAIL stall_hold: s_ready %b m_valid %b want 0/1", s_ready, m_valid); end
      checks++; if ({m_pass, m_len, m_residue} !== {pass0, len0, res0}) begin errors++; $display("FAIL stall_stable: len %0d res %h want %0d %h", m_len, m_residue, len0, res0); end
    end
    m_ready = 1'b1;
    step();
    checks++; if ({s_ready, m_valid} !== 2'b10) begin errors++; $display("FAIL stall_release: s_ready %b m_valid %b want 1/0", s_ready, m_valid); end
  endtask

  task automatic test_corrupt;
    frame = saved;
    begin
      logic [31:0] tmp;
      tmp = frame[2]; tmp[7] = ~tmp[7]; frame[2] = tmp;
    end
    drive_words(5, 1'b0); exp_bad++;
    checks++; if (m_pass !== 1'b0) begin errors++; $display("FAIL corrupt_pass: got %b want 0", m_pass); end
    checks++; if (m_residue !== ref_crc(5)) begin errors++; $display("FAIL corrupt_res: got %h want %h", m_residue, ref_crc(5)); end
    checks++; if (cnt_bad !== 16'(exp_bad)) begin errors++; $display("FAIL corrupt_cnt: got %0d want %0d", cnt_bad, exp_bad); end
    step();
    frame = saved;
    drive_words(5, 1'b0); exp_good++;
    checks++; if ({m_valid, m_pass, m_residue} !== {2'b11, 32'h0}) begin errors++; $display("FAIL reload_pass: pass %b res %h want 1/0", m_pass, m_residue); end
    checks++; if (cnt_good !== 16'(exp_good)) begin errors++; $display("FAIL reload_cnt: got %0d want %0d", cnt_good, exp_good); end
    step();
  endtask

  task automatic test_reset_midframe;
    build_frame(5, -1, 0);
    drive_words(3, 1'b0);
    rst = 1'b1;
    #1;
    exp_good = 0; exp_bad = 0;
    checks++; if ({s_ready, m_valid} !== 2'b10) begin errors++; $display("FAIL midrst_hs: s_ready %b m_valid %b want 1/0", s_ready, m_valid); end
    checks++; if ({cnt_good, cnt_bad} !== 32'h0) begin errors++; $display("FAIL midrst_cnt: good %0d bad %0d want 0", cnt_good, cnt_bad); end
    @(negedge clk); rst = 1'b0;
    step();
    build_frame(1, -1, 0);
    drive_words(2, 1'b0); exp_good++;
    checks++; if ({m_valid, m_pass} !== 2'b11) begin errors++; $display("FAIL midrst_next_pass: valid %b pass %b want 1/1", m_valid, m_pass); end
    checks++; if ((m_len !== 16'd2) || (m_len_s !== 2'd2)) begin errors++; $display("FAIL midrst_next_len: got %0d/%0d want 2", m_len, m_len_s); end
    checks++; if (cnt_good !== 16'(exp_good)) begin errors++; $display("FAIL midrst_next_cnt: got %0d want %0d", cnt_good, exp_good); end
    step();
  endtask

  task automatic test_counters;
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    exp_good = 0; exp_bad = 0;
    checks++; if ({cnt_good, cnt_bad, cnt_good_s, cnt_bad_s} !== 36'h0) begin errors++; $display("FAIL clr_idle: good %0d bad %0d want 0", cnt_good, cnt_bad); end
    for (int f = 0; f < 5; f++) begin
      build_frame($urandom_range(0, 3), -1, 0);
      drive_words(frame.size(), 1'b0); exp_good++;
      step();
    end
    checks++; if (cnt_good !== 16'(exp_good)) begin errors++; $display("FAIL cnt_wide: got %0d want %0d", cnt_good, exp_good); end
    checks++; if (cnt_good_s !== sat2(exp_good)) begin errors++; $display("FAIL cnt_sat: got %0d want %0d", cnt_good_s, sat2(exp_good)); end
    build_frame(1, -1, 0);
    drive_words(2, 1'b1); exp_good = 0; exp_bad = 0;
    checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL clr_coincide_pass: got %b want 1", m_pass); end
    checks++; if ({cnt_good, cnt_good_s} !== 18'h0) begin errors++; $display("FAIL clr_coincide_cnt: got %0d/%0d want 0", cnt_good, cnt_good_s); end
    step();
  endtask

  task automatic test_len_sat;
    build_frame(5, -1, 0);
    drive_words(6, 1'b0); exp_good++;
    checks++; if ({m_len_s, m_pass_s} !== {2'd3, 1'b1}) begin errors++; $display("FAIL lensat_small: len %0d pass %b want 3/1", m_len_s, m_pass_s); end
    checks++; if (m_len !== 16'd6) begin errors++; $display("FAIL lensat_wide: got %0d want 6", m_len); end
    step();
  endtask

  task automatic test_random;
    int          n, d;
    logic [31:0] er;
    gaps_en = 1;
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) build_frame(n, $urandom_range(0, n), $urandom_range(0, 31));
      else                           build_frame(n, -1, 0);
      m_ready = 1'b0;
      drive_words(frame.size(), 1'b0);
      er = ref_crc(frame.size());
      if (er == 32'h0) exp_good++; else exp_bad++;
      checks++; if ({m_valid, m_pass, m_residue} !== {1'b1, er == 32'h0, er}) begin errors++; $display("FAIL rand_record[%0d]: pass %b res %h want %b %h", f, m_pass, m_residue, er == 32'h0, er); end
      checks++; if ((m_len !== 16'(frame.size())) || (m_len_s !== sat2(frame.size()))) begin errors++; $display("FAIL rand_len[%0d]: got %0d/%0d want %0d", f, m_len, m_len_s, frame.size()); end
      checks++; if ({cnt_good, cnt_bad} !== {16'(exp_good), 16'(exp_bad)}) begin errors++; $display("FAIL rand_cnt[%0d]: good %0d bad %0d want %0d %0d", f, cnt_good, cnt_bad, exp_good, exp_bad); end
      d = $urandom_range(0, 2);
      repeat (d) step();
      m_ready = 1'b1;
      step();
      checks++; if ({s_ready, m_valid} !== 2'b10) begin errors++; $display("FAIL rand_release[%0d]: s_ready %b m_valid %b want 1/0", f, s_ready, m_valid); end
    end
    gaps_en = 0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0;
    m_ready = 1'b1; clr_cnt = 1'b0;
    test_reset();
    test_single_word();
    test_stall();
    test_corrupt();
    test_reset_midframe();
    test_counters();
    test_len_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
